// File: rtl/zeroheti_sba_obi_mgr.sv
// Bridge from the debug module's SBA manager port to an OBI manager port.
// Single request register, in-order responses, response timeout with discard of late responses.
module zeroheti_sba_obi_mgr #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned IdWidth        = 2,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,

    input  logic                                  sba_req_i,
    input  logic [AddrWidth-1:0]                  sba_addr_i,
    input  logic                                  sba_we_i,
    input  logic [DataWidth-1:0]                  sba_wdata_i,
    input  logic [DataWidth/8-1:0]                sba_be_i,
    output logic                                  sba_gnt_o,
    output logic                                  sba_rvalid_o,
    output logic [DataWidth-1:0]                  sba_rdata_o,
    output logic                                  sba_err_o,
    output logic                                  sba_other_err_o,

    output logic                                  obi_req_o,
    input  logic                                  obi_gnt_i,
    output logic [AddrWidth-1:0]                  obi_addr_o,
    output logic                                  obi_we_o,
    output logic [DataWidth/8-1:0]                obi_be_o,
    output logic [DataWidth-1:0]                  obi_wdata_o,
    output logic [IdWidth-1:0]                    obi_aid_o,
    input  logic                                  obi_rvalid_i,
    input  logic [DataWidth-1:0]                  obi_rdata_i,
    input  logic [IdWidth-1:0]                    obi_rid_i,
    input  logic                                  obi_err_i,

    output logic                                  timeout_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam int unsigned TmrWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TmrWidth-1:0] TmrLast = TmrWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam logic [IdWidth-1:0]  IdLast  = IdWidth'(MaxOutstanding - 1);
    localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MaxOutstanding);

    logic                pending;
    logic [IdWidth-1:0]  issue_id;
    logic [IdWidth-1:0]  expect_id;
    logic [CntWidth-1:0] outstanding;
    logic [CntWidth-1:0] stale;
    logic [CntWidth-1:0] live;
    logic [CntWidth-1:0] outstanding_nxt;
    logic [CntWidth-1:0] stale_nxt;
    logic [TmrWidth-1:0] timer;
    logic                issue_hs;
    logic                fwd;
    logic                discard;
    logic                run;
    logic                fire;

    function automatic logic [IdWidth-1:0] next_id(input logic [IdWidth-1:0] id);
        return (id == IdLast) ? '0 : id + 1'b1;
    endfunction

    assign sba_gnt_o     = sba_req_i && !pending && (outstanding < CntMax);
    assign obi_req_o     = pending;
    assign outstanding_o = outstanding;

    assign issue_hs = pending && obi_gnt_i;
    assign fwd      = obi_rvalid_i && (stale == '0);
    assign discard  = obi_rvalid_i && (stale != '0);
    assign live     = outstanding - stale;

    // The timer also counts the issue cycle, so the deadline is measured from the OBI grant.
    assign run  = (TimeoutCycles != 0) && ((live != '0) || issue_hs);
    assign fire = run && !fwd && (timer == TmrLast);

    assign outstanding_nxt = outstanding + CntWidth'(issue_hs) - CntWidth'(obi_rvalid_i);
    assign stale_nxt       = stale + CntWidth'(fire) - CntWidth'(discard);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending         <= 1'b0;
            obi_addr_o      <= '0;
            obi_we_o        <= 1'b0;
            obi_be_o        <= '0;
            obi_wdata_o     <= '0;
            obi_aid_o       <= '0;
            issue_id        <= '0;
            expect_id       <= '0;
            outstanding     <= '0;
            stale           <= '0;
            timer           <= '0;
            timeout_o       <= 1'b0;
            sba_rvalid_o    <= 1'b0;
            sba_rdata_o     <= '0;
            sba_err_o       <= 1'b0;
            sba_other_err_o <= 1'b0;
        end else begin
            if (sba_gnt_o) begin
                pending     <= 1'b1;
                obi_addr_o  <= sba_addr_i;
                obi_we_o    <= sba_we_i;
                obi_be_o    <= sba_be_i;
                obi_wdata_o <= sba_wdata_i;
                obi_aid_o   <= issue_id;
            end else if (issue_hs) begin
                pending <= 1'b0;
            end

            if (issue_hs) begin
                issue_id <= next_id(issue_id);
            end
            if (obi_rvalid_i) begin
                expect_id <= next_id(expect_id);
            end

            outstanding <= outstanding_nxt;
            stale       <= stale_nxt;

            if (fwd || fire || (outstanding_nxt == stale_nxt)) begin
                timer <= '0;
            end else if (run) begin
                timer <= timer + 1'b1;
            end

            timeout_o <= fire;

            // A forwarded response takes priority over a timeout in the same cycle.
            if (fwd) begin
                sba_rvalid_o    <= 1'b1;
                sba_rdata_o     <= obi_err_i ? '0 : obi_rdata_i;
                sba_err_o       <= obi_err_i;
                sba_other_err_o <= (obi_rid_i != expect_id);
            end else if (fire) begin
                sba_rvalid_o    <= 1'b1;
                sba_rdata_o     <= '0;
                sba_err_o       <= 1'b0;
                sba_other_err_o <= 1'b1;
            end else begin
                sba_rvalid_o    <= 1'b0;
                sba_rdata_o     <= '0;
                sba_err_o       <= 1'b0;
                sba_other_err_o <= 1'b0;
            end
        end
    end

endmodule
